// File: rtl/cracker_host_link.sv
// cracker_host_link
// -----------------
// Host-side sequencer for an NT-hash cracker core. A job runs in three phases:
//   1. Hash load: HASH_BYTES bytes are accepted from the host one at a time.
//      Each byte is registered onto new_hash_byte and announced to the core
//      with a one-cycle store_hash_byte strobe (two cycles per byte).
//   2. Start/capture: a one-cycle go strobe starts the core. The core then
//      presents the recovered password one byte per your_turn cycle. An
//      8'h00 byte terminates it. match_found is latched from the first
//      your_turn cycle. At most MAX_PW_BYTES bytes are buffered.
//   3. Drain: buffered bytes are returned to the host, oldest first, over a
//      valid/ready handshake. The block returns to IDLE once the buffer is
//      empty.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   host_byte/valid/ready       hash bytes from host
//   new_hash_byte               hash byte presented to the cracker core
//   store_hash_byte, go         one-cycle strobes to the cracker core
//   match_found, your_turn,
//   password_byte               result stream from the cracker core
//   result_byte/valid/ready     buffered password bytes to host
//   result_match                match flag latched for the current job
//   busy                        high whenever not IDLE
module cracker_host_link #(
  parameter int HASH_BYTES   = 16,
  parameter int MAX_PW_BYTES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_byte,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [7:0] new_hash_byte,
  output logic       store_hash_byte,
  output logic       go,
  input  logic       match_found,
  input  logic       your_turn,
  input  logic [7:0] password_byte,
  output logic [7:0] result_byte,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       result_match,
  output logic       busy
);

  localparam int HC_W  = $clog2(HASH_BYTES + 1);
  localparam int PC_W  = $clog2(MAX_PW_BYTES + 1);
  localparam int IDX_W = (MAX_PW_BYTES > 1) ? $clog2(MAX_PW_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  state_t            state_reg, state_next;
  logic [HC_W-1:0]   hash_cnt_reg, hash_cnt_next;
  logic [7:0]        hash_byte_reg, hash_byte_next;
  logic [PC_W-1:0]   wr_cnt_reg, wr_cnt_next;
  logic [PC_W-1:0]   rd_cnt_reg, rd_cnt_next;
  logic              match_reg, match_next;
  logic [7:0]        rd_data_reg;

  logic              mem_we;
  logic              pop;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Password capture buffer. It is never reset: the write and read counters
  // define which entries are meaningful. Clearing the counters empties it.
  logic [7:0] pw_mem [MAX_PW_BYTES];

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    hash_cnt_next   = hash_cnt_reg;
    hash_byte_next  = hash_byte_reg;
    wr_cnt_next     = wr_cnt_reg;
    rd_cnt_next     = rd_cnt_reg;
    match_next      = match_reg;
    host_ready      = 1'b0;
    store_hash_byte = 1'b0;
    go              = 1'b0;
    result_valid    = 1'b0;
    mem_we          = 1'b0;
    pop             = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Only wake up here. The byte is taken in LOAD on the next cycle.
        if (host_valid) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        host_ready = 1'b1;
        if (host_valid) begin
          hash_byte_next = host_byte;
          state_next     = ST_STORE;
        end
      end

      ST_STORE: begin
        store_hash_byte = 1'b1;
        hash_cnt_next   = hash_cnt_reg + HC_W'(1);
        // Compare before the increment so the counter never has to hold
        // more than HASH_BYTES.
        if (hash_cnt_reg == HC_W'(HASH_BYTES - 1)) begin
          state_next = ST_START;
        end else begin
          state_next = ST_LOAD;
        end
      end

      ST_START: begin
        go            = 1'b1;
        hash_cnt_next = '0;
        wr_cnt_next   = '0;
        rd_cnt_next   = '0;
        match_next    = 1'b0;
        state_next    = ST_WAIT;
      end

      ST_WAIT, ST_CAPTURE: begin
        if (your_turn) begin
          // The match flag is taken only from the first presented byte.
          if (state_reg == ST_WAIT) begin
            match_next = match_found;
          end
          if (password_byte == 8'h00) begin
            state_next = ST_DRAIN;
          end else begin
            mem_we      = 1'b1;
            wr_cnt_next = wr_cnt_reg + PC_W'(1);
            if (wr_cnt_reg == PC_W'(MAX_PW_BYTES - 1)) begin
              state_next = ST_DRAIN;
            end else begin
              state_next = ST_CAPTURE;
            end
          end
        end
      end

      ST_DRAIN: begin
        if (rd_cnt_reg != wr_cnt_reg) begin
          result_valid = 1'b1;
          if (result_ready) begin
            pop         = 1'b1;
            rd_cnt_next = rd_cnt_reg + PC_W'(1);
          end
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      hash_cnt_reg  <= '0;
      hash_byte_reg <= 8'h00;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      match_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hash_cnt_reg  <= hash_cnt_next;
      hash_byte_reg <= hash_byte_next;
      wr_cnt_reg    <= wr_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      match_reg     <= match_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer write port and registered read port
  // ---------------------------------------------------------------------------
  assign wr_idx = wr_cnt_reg[IDX_W-1:0];
  // The read register is addressed with the entry that will be at the head on
  // the next cycle, so the head is always ready without extra latency.
  assign rd_idx = rd_cnt_reg[IDX_W-1:0] + (pop ? IDX_W'(1) : IDX_W'(0));

  always_ff @(posedge clk) begin
    if (mem_we) begin
      pw_mem[wr_idx] <= password_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= 8'h00;
    end else if (mem_we && (wr_idx == rd_idx)) begin
      // Forward a byte that is written to the head slot in this same cycle.
      rd_data_reg <= password_byte;
    end else begin
      rd_data_reg <= pw_mem[rd_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign new_hash_byte = hash_byte_reg;
  assign result_byte   = result_valid ? rd_data_reg : 8'h00;
  assign result_match  = match_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cracker_host_link.sv
module tb_cracker_host_link;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] host_byte;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] new_hash_byte;
  logic       store_hash_byte;
  logic       go;
  logic       match_found;
  logic       your_turn;
  logic [7:0] password_byte;
  logic [7:0] result_byte;
  logic       result_valid;
  logic       result_ready;
  logic       result_match;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  cracker_host_link #(.HASH_BYTES(16), .MAX_PW_BYTES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .host_byte      (host_byte),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .new_hash_byte  (new_hash_byte),
    .store_hash_byte(store_hash_byte),
    .go             (go),
    .match_found    (match_found),
    .your_turn      (your_turn),
    .password_byte  (password_byte),
    .result_byte    (result_byte),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_match   (result_match),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base_hash;
    logic [7:0] pw [20];
    int         n_pw;
    bit         match;
    int         stall;
    bit         gaps;
    int         exp_n;
  } job_t;

  job_t jobs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    host_valid = 1'b0;
    your_turn = 1'b0;
    result_ready = 1'b0;
    step();
    step();
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_store", 32'(store_hash_byte), 0);
    chk("rst_go", 32'(go), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_result_match", 32'(result_match), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_new_hash_byte", 32'(new_hash_byte), 0);
    chk("rst_result_byte", 32'(result_byte), 0);
    reset = 1'b0;
  endtask

  // Feeds bytes base, base+1, ... and checks each store strobe. With
  // n_stop == 16 the single go pulse that follows is checked as well and the
  // task returns in the WAIT state.
  task automatic load_hash(input logic [7:0] base, input int n_stop);
    int idx = 0;
    int cyc = 0;
    int last = 0;
    host_valid = 1'b1;
    host_byte = base;
    for (int c = 0; c < 200 && idx < n_stop; c++) begin
      step();
      cyc++;
      chk("load_go_early", 32'(go), 0);
      if (store_hash_byte) begin
        chk("store_byte", 32'(new_hash_byte), 32'(base + idx[7:0]));
        chk("store_host_ready", 32'(host_ready), 0);
        if (idx > 0) chk("store_gap", 32'(cyc - last), 2);
        last = cyc;
        idx++;
        host_byte = base + idx[7:0];
        if (idx == n_stop) host_valid = 1'b0;
      end
    end
    host_valid = 1'b0;
    chk("load_store_count", 32'(idx), 32'(n_stop));
    if (n_stop == 16) begin
      step();
      chk("go_pulse", 32'(go), 1);
      chk("go_store_overlap", 32'(store_hash_byte), 0);
      step();
      chk("go_single", 32'(go), 0);
      chk("busy_wait", 32'(busy), 1);
    end
  endtask

  task automatic run_job(input int j);
    int got = 0;
    logic [7:0] hold;
    load_hash(jobs[j].base_hash, 16);
    result_ready = 1'b0;
    for (int i = 0; i < jobs[j].n_pw; i++) begin
      your_turn = 1'b1;
      password_byte = jobs[j].pw[i];
      match_found = (i == 0) ? jobs[j].match : !jobs[j].match;
      step();
      if (jobs[j].gaps) begin
        // Idle cycle with a nonzero byte that must not be captured.
        your_turn = 1'b0;
        password_byte = 8'hFF;
        match_found = !jobs[j].match;
        step();
      end
    end
    your_turn = 1'b0;
    password_byte = 8'h00;
    match_found = 1'b0;
    chk("result_match", 32'(result_match), 32'(jobs[j].match));
    if (jobs[j].stall > 0) begin
      chk("stall_valid0", 32'(result_valid), 1);
      hold = result_byte;
      for (int s = 0; s < jobs[j].stall; s++) begin
        step();
        chk("stall_valid", 32'(result_valid), 1);
        chk("stall_byte", 32'(result_byte), 32'(hold));
      end
    end
    result_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!result_valid) break;
      if (got < jobs[j].exp_n) chk("result_byte", 32'(result_byte), 32'(jobs[j].pw[got]));
      else chk("result_extra", 32'(got), 32'(jobs[j].exp_n));
      got++;
      step();
    end
    chk("result_count", 32'(got), 32'(jobs[j].exp_n));
    chk("drain_match_hold", 32'(result_match), 32'(jobs[j].match));
    step();
    result_ready = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    $display("job %0d: hash base 0x%02h, %0d bytes returned, match=%0d", j,
             jobs[j].base_hash, got, result_match);
  endtask

  initial begin
    int go_cnt;
    host_byte = 8'h00;
    host_valid = 1'b0;
    match_found = 1'b0;
    your_turn = 1'b0;
    password_byte = 8'h00;
    result_ready = 1'b0;
    reset = 1'b1;

    // Job table: expected returned bytes are the first exp_n entries of pw.
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 20; i++) jobs[j].pw[i] = 8'h00;
      jobs[j].stall = 0;
      jobs[j].gaps = 1'b0;
    end
    jobs[0].base_hash = 8'h00; jobs[0].n_pw = 4; jobs[0].match = 1'b1; jobs[0].exp_n = 3;
    jobs[0].pw[0] = 8'h61; jobs[0].pw[1] = 8'h62; jobs[0].pw[2] = 8'h63; jobs[0].pw[3] = 8'h00;
    jobs[1].base_hash = 8'h10; jobs[1].n_pw = 1; jobs[1].match = 1'b0; jobs[1].exp_n = 0;
    jobs[2].base_hash = 8'h20; jobs[2].n_pw = 20; jobs[2].match = 1'b1; jobs[2].exp_n = 16;
    jobs[2].gaps = 1'b1;
    for (int i = 0; i < 20; i++) jobs[2].pw[i] = 8'h41 + 8'(i);
    jobs[3].base_hash = 8'h30; jobs[3].n_pw = 4; jobs[3].match = 1'b0; jobs[3].exp_n = 3;
    jobs[3].stall = 5;
    jobs[3].pw[0] = 8'h78; jobs[3].pw[1] = 8'h79; jobs[3].pw[2] = 8'h7a; jobs[3].pw[3] = 8'h00;

    do_reset();
    for (int j = 0; j < 4; j++) run_job(j);

    // Mid-load abort: reset after the 7th hash byte, then no go may follow.
    load_hash(8'h40, 7);
    reset = 1'b1;
    step();
    chk("abort_go", 32'(go), 0);
    chk("abort_store", 32'(store_hash_byte), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_new_hash_byte", 32'(new_hash_byte), 0);
    reset = 1'b0;
    go_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (go || store_hash_byte) go_cnt++;
    end
    chk("abort_no_strobe", 32'(go_cnt), 0);
    $display("abort: reset after 7 hash bytes, %0d strobes afterwards", go_cnt);

    // Fresh complete job after the abort.
    jobs[0].base_hash = 8'h50;
    run_job(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cracker_host_link.md
CRACKER_HOST_LINK -- requirements
Module: cracker_host_link

Interface
REQ-001 Parameter HASH_BYTES, default 16, number of NT-hash bytes loaded per job.
REQ-002 Parameter MAX_PW_BYTES, default 16, depth of the password capture buffer.
REQ-003 clk  input  1  system clock, sourced from the on-chip oscillator; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 host_byte  input  8  hash byte offered by host.
REQ-006 host_valid  input  1  host_byte valid.
REQ-007 host_ready  output  1  block accepts host_byte this cycle.
REQ-008 new_hash_byte  output  8  hash byte to cracker core.
REQ-009 store_hash_byte  output  1  one-cycle strobe: cracker stores new_hash_byte.
REQ-010 go  output  1  one-cycle strobe: start cracking.
REQ-011 match_found  input  1  cracker result flag, sampled while your_turn high.
REQ-012 your_turn  input  1  cracker presents password_byte this cycle.
REQ-013 password_byte  input  8  password byte from cracker; 8'h00 terminates.
REQ-014 result_byte  output  8  buffered password byte to host.
REQ-015 result_valid  output  1  result_byte valid.
REQ-016 result_ready  input  1  host consumes result_byte.
REQ-017 result_match  output  1  latched match_found of current job.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, LOAD, STORE, START, WAIT, CAPTURE, DRAIN.
REQ-020 IDLE: host_valid high -> LOAD next cycle; no byte consumed in IDLE.
REQ-021 LOAD: host_ready=1; transfer when host_valid&host_ready; byte registered to new_hash_byte, state -> STORE.
REQ-022 STORE: store_hash_byte=1 exactly one cycle, host_ready=0; byte counter increments; counter<HASH_BYTES -> LOAD, counter==HASH_BYTES -> START.
REQ-023 new_hash_byte SHALL stay stable from its load until the next transfer.
REQ-024 Minimum load latency: 2 cycles per byte; 2*HASH_BYTES cycles from first transfer to START.
REQ-025 START: go=1 exactly one cycle, byte counter cleared, buffer cleared, -> WAIT.
REQ-026 WAIT: first cycle with your_turn=1: result_match<=match_found; same byte handled as in CAPTURE; -> CAPTURE (or DRAIN if terminated).
REQ-027 CAPTURE: each your_turn=1 cycle with nonzero password_byte writes one buffer entry; cycles with your_turn=0 ignored.
REQ-028 Termination: password_byte==8'h00 with your_turn=1, or buffer reaching MAX_PW_BYTES entries -> DRAIN; further your_turn bytes ignored.
REQ-029 result_match SHALL not change after first latch until next START or reset.
REQ-030 DRAIN: result_valid=1 while entries remain; result_byte = oldest entry; entry popped when result_valid&result_ready.
REQ-031 Buffer empty in DRAIN (including zero-length password) -> IDLE next cycle; result_valid=0 in that cycle.
REQ-032 host_valid in any state other than IDLE/LOAD SHALL be ignored, host_ready=0.
REQ-033 store_hash_byte and go SHALL never be high in the same cycle.
REQ-034 Counters SHALL be sized ceil(log2(param+1)); no wrap-around permitted.

Reset
REQ-035 reset=1 SHALL, at next edge, force IDLE, clear counters and buffer, and drive host_ready=0, store_hash_byte=0, go=0, result_valid=0, result_match=0, busy=0, new_hash_byte=8'h00, result_byte=8'h00.
REQ-036 reset mid-job (any state) SHALL abort without emitting a further strobe; reset has priority over all inputs.

Verification
REQ-037 Load 16 bytes 0x00..0x0F back-to-back -> 16 store_hash_byte pulses 2 cycles apart with matching new_hash_byte, then single go pulse.
REQ-038 After go, your_turn bytes "abc",0x00 with match_found=1 -> result_match=1, host receives 0x61,0x62,0x63, then IDLE, busy=0.
REQ-039 your_turn with match_found=0 and password_byte=0x00 -> result_match=0, no result_valid, IDLE next cycle.
REQ-040 20 nonzero bytes without terminator -> only first 16 returned, remainder ignored.
REQ-041 result_ready held low 5 cycles in DRAIN -> result_byte/result_valid stable, no loss.
REQ-042 reset asserted after 7th hash byte -> no go pulse; fresh 16-byte load then completes normally.
